ysyx_25020047_exu_mc: RTL and testbench

YSYX_25020047_EXU_MC -- requirements
Module: ysyx_25020047_exu_mc

---
 rtl/ysyx_25020047_exu_mc.sv | 176 +++++++++++++++++
 tb/tb_ysyx_25020047_exu_mc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25020047_exu_mc.sv
// Multi-cycle execute unit: single-cycle ALU ops, bit-serial shifts and
// single-beat loads behind valid/ready handshakes on both sides.
module ysyx_25020047_exu_mc #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OPW  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  op,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_wen,
    output logic            ebreak,
    output logic            illegal,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    output logic [1:0]      mem_size,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned ShW = $clog2(XLEN);
    localparam logic [OPW-1:0] OpMask = OPW'(10'h3FF);

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StMemReq,
        StMemWait,
        StDone
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;
    logic            wen_q;
    logic            ebreak_q;
    logic            illegal_q;
    logic [XLEN-1:0] addr_q;
    logic [1:0]      size_q;
    logic            lbu_q;
    logic            srl_q;
    logic [ShW-1:0]  cnt_q;

    logic            is_legal;
    logic            writes_rd;
    logic [XLEN-1:0] sum_imm;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] load_val;
    logic [ShW-1:0]  shamt;
    logic [7:0]      load_byte;

    // Legal means exactly one bit set, and that bit is one of the ten decoded ops.
    always_comb begin
        is_legal  = (op != '0) && ((op & (op - OPW'(1))) == '0) && ((op & OpMask) != '0);
        writes_rd = op[0] | op[1] | op[3] | op[4] | op[5] | op[6] | op[7] | op[8] | op[9];
        sum_imm   = rdata1 + imm;
        shamt     = rdata2[ShW-1:0];
    end

    always_comb begin
        alu_res = '0;
        if (op[0]) begin
            alu_res = sum_imm;
        end else if (op[1]) begin
            alu_res = {sum_imm[XLEN-1:1], 1'b0};
        end else if (op[3]) begin
            alu_res = rdata1 + rdata2;
        end else if (op[4]) begin
            alu_res = imm;
        end else if (op[7]) begin
            alu_res = rdata1 - rdata2;
        end
    end

    always_comb begin
        load_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        if (lbu_q) begin
            load_val = XLEN'(load_byte);
        end else begin
            load_val = XLEN'(mem_rdata[31:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            result_q  <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            ebreak_q  <= 1'b0;
            illegal_q <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            lbu_q     <= 1'b0;
            srl_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        rd_q      <= rd;
                        wen_q     <= is_legal && writes_rd && (rd != 5'd0);
                        ebreak_q  <= is_legal && op[2];
                        illegal_q <= !is_legal;
                        if (!is_legal) begin
                            result_q <= '0;
                            state_q  <= StDone;
                        end else if (op[5] || op[6]) begin
                            addr_q  <= sum_imm;
                            size_q  <= op[5] ? 2'b10 : 2'b00;
                            lbu_q   <= op[6];
                            state_q <= StMemReq;
                        end else if (op[8] || op[9]) begin
                            // result_q doubles as the shift working register.
                            result_q <= rdata1;
                            cnt_q    <= shamt;
                            srl_q    <= op[9];
                            state_q  <= (shamt == '0) ? StDone : StShift;
                        end else begin
                            result_q <= alu_res;
                            state_q  <= StDone;
                        end
                    end
                end
                StShift: begin
                    result_q <= srl_q ? (result_q >> 1) : (result_q << 1);
                    cnt_q    <= cnt_q - ShW'(1);
                    if (cnt_q == ShW'(1)) begin
                        state_q <= StDone;
                    end
                end
                StMemReq: begin
                    state_q <= StMemWait;
                end
                StMemWait: begin
                    if (mem_rvalid) begin
                        result_q <= load_val;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs are forced to their idle values whenever reset is high.
    always_comb begin
        in_ready  = rst || (state_q == StIdle);
        out_valid = !rst && (state_q == StDone);
        mem_req   = !rst && (state_q == StMemReq);
        reg_wen   = out_valid && wen_q;
        ebreak    = out_valid && ebreak_q;
        illegal   = out_valid && illegal_q;
        result    = rst ? '0 : result_q;
        rd_out    = rst ? 5'd0 : rd_q;
        mem_addr  = rst ? '0 : addr_q;
        mem_size  = rst ? 2'b00 : size_q;
    end

endmodule

// File: tb/tb_ysyx_25020047_exu_mc.sv
// Directed bench for ysyx_25020047_exu_mc: a driver pushes expected results
// into queues, independent monitors pop and compare when the DUT responds.
module tb_ysyx_25020047_exu_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  op;
    logic [31:0] rdata1, rdata2, imm;
    logic [4:0]  rd;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_wen, ebreak, illegal;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    ysyx_25020047_exu_mc #(.XLEN(32), .OPW(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .imm       (imm),
        .rd        (rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rd_out    (rd_out),
        .reg_wen   (reg_wen),
        .ebreak    (ebreak),
        .illegal   (illegal),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_size  (mem_size),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
        logic        eb;
        logic        ill;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
    } mexp_t;

    exp_t  sb[$];
    mexp_t mq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cur_cycles  = 0;
    int last_cycles = 0;

    bit          mem_auto  = 1'b1;
    int          mem_delay = 1;
    logic [31:0] mem_data  = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result monitor: compare every cycle out_valid is high, pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb[0];
                    if (cur_cycles == 0 && e.lat != 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                    chk("result", result, e.res);
                    chk("rd_out", rd_out, e.rd);
                    chk("reg_wen", reg_wen, e.wen);
                    chk("ebreak", ebreak, e.eb);
                    chk("illegal", illegal, e.ill);
                    cur_cycles++;
                    if (out_ready) begin
                        void'(sb.pop_front());
                        last_cycles = cur_cycles;
                        cur_cycles  = 0;
                    end
                end
            end
        end
    end

    // Memory request monitor: address/size on mem_req, and the pulse lasts one cycle.
    initial begin
        mexp_t m;
        bit prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_req) chk("mem_req_one_cycle", mem_req, 1'b0);
            if (mem_req && !prev_req) begin
                if (mq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    m = mq.pop_front();
                    chk("mem_addr", mem_addr, m.addr);
                    chk("mem_size", mem_size, m.size);
                end
            end
            prev_req = mem_req;
        end
    end

    // Memory responder: rvalid mem_delay cycles after the request cycle.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req && mem_auto) begin
                repeat (mem_delay) @(posedge clk);
                #1;
                mem_rvalid = 1'b1;
                mem_rdata  = mem_data;
                @(posedge clk);
                #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (in_ready) return;
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
    endtask

    task automatic issue(input logic [9:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] i, input logic [4:0] d, input logic [31:0] res,
                         input bit wen, input bit eb, input bit ill, input int lat,
                         input bit push);
        exp_t e;
        wait_idle();
        op = o; rdata1 = a; rdata2 = b; imm = i; rd = d;
        in_valid = 1'b1;
        e.res = res; e.rd = d; e.wen = wen; e.eb = eb; e.ill = ill; e.acc = cyc; e.lat = lat;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (push) sb.push_back(e);
    endtask

    initial begin
        mexp_t m;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; rdata1 = '0; rdata2 = '0; imm = '0; rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_flags", {reg_wen, ebreak, illegal}, 3'b000);
        chk("rst_result", result, 32'h0);
        chk("rst_rd_out", rd_out, 5'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_size", mem_size, 2'b00);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-cycle ALU ops
        issue(10'h008, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'd5, 32'h0000_0001, 1, 0, 0, 1, 1);
        issue(10'h080, 32'h5, 32'h7, 32'h0, 5'd3, 32'hFFFF_FFFE, 1, 0, 0, 1, 1);
        issue(10'h001, 32'h100, 32'h0, 32'hFFFF_FFFF, 5'd1, 32'h0000_00FF, 1, 0, 0, 1, 1);
        issue(10'h002, 32'h1001, 32'h0, 32'h4, 5'd1, 32'h0000_1004, 1, 0, 0, 1, 1);
        issue(10'h010, 32'h0, 32'h0, 32'h1234_5000, 5'd0, 32'h1234_5000, 0, 0, 0, 1, 1);

        // Shifts: zero shamt, full shift with busy check, right shift
        issue(10'h100, 32'hDEAD_BEEF, 32'h20, 32'h0, 5'd2, 32'hDEAD_BEEF, 1, 0, 0, 1, 1);
        issue(10'h100, 32'h1, 32'd31, 32'h0, 5'd2, 32'h8000_0000, 1, 0, 0, 32, 1);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) break;
            chk("sll_in_ready_busy", in_ready, 1'b0);
            @(posedge clk);
            #1;
        end
        issue(10'h200, 32'h8000_0000, 32'h4, 32'h0, 5'd8, 32'h0800_0000, 1, 0, 0, 5, 1);

        // Loads
        wait_idle();
        mem_delay = 1; mem_data = 32'h1122_3344;
        m.addr = 32'h0000_1008; m.size = 2'b10; mq.push_back(m);
        issue(10'h020, 32'h1000, 32'h0, 32'h8, 5'd7, 32'h1122_3344, 1, 0, 0, 3, 1);
        wait_idle();
        mem_delay = 4; mem_data = 32'hAABB_CCDD;
        m.addr = 32'h8000_0003; m.size = 2'b00; mq.push_back(m);
        issue(10'h040, 32'h8000_0000, 32'h0, 32'h3, 5'd6, 32'h0000_00AA, 1, 0, 0, 6, 1);
        wait_idle();
        mem_delay = 2;
        m.addr = 32'h8000_0001; m.size = 2'b00; mq.push_back(m);
        issue(10'h040, 32'h8000_0000, 32'h0, 32'h1, 5'd6, 32'h0000_00CC, 1, 0, 0, 4, 1);

        // Illegal encodings and ebreak
        issue(10'h003, 32'h5, 32'h5, 32'h5, 5'd9, 32'h0, 0, 0, 1, 1, 1);
        issue(10'h000, 32'h5, 32'h5, 32'h5, 5'd9, 32'h0, 0, 0, 1, 1, 1);
        issue(10'h004, 32'h5, 32'h5, 32'h5, 5'd4, 32'h0, 0, 1, 0, 1, 1);

        // Backpressure: out_ready low for 3 cycles while in_valid is held high
        wait_idle();
        out_ready = 1'b0;
        issue(10'h001, 32'h10, 32'h0, 32'h20, 5'd11, 32'h0000_0030, 1, 0, 0, 1, 1);
        op = 10'h008; rdata1 = 32'h1; rdata2 = 32'h1; rd = 5'd12;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_valid_cycles", 64'(last_cycles), 64'd4);
        chk("bp_in_ready_after", in_ready, 1'b1);
        chk("bp_out_valid_after", out_valid, 1'b0);

        // Reset while waiting for memory, then a stale rvalid
        wait_idle();
        mem_auto = 1'b0;
        m.addr = 32'h0000_2000; m.size = 2'b10; mq.push_back(m);
        issue(10'h020, 32'h2000, 32'h0, 32'h0, 5'd9, 32'h0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mw_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("late_rvalid_in_ready", in_ready, 1'b1);
            chk("late_rvalid_out_valid", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        mem_auto = 1'b1;

        issue(10'h008, 32'h7, 32'h8, 32'h0, 5'd31, 32'h0000_000F, 1, 0, 0, 1, 1);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("mq_drained", 64'(mq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
